// File: rtl/cci_mpf_csrs_pkg.sv
// Shared MPF CSR types and register map.
// Used by the MMIO responder and its response FIFO.
package cci_mpf_csrs_pkg;

  typedef struct packed {
    logic inval_translation_cache;
    logic enabled;
  } t_cci_mpf_vtp_csr_mode;

  typedef struct packed {
    logic [8:0]  tid;
    logic [63:0] data;
  } t_cci_mpf_csr_rd_rsp;

  localparam logic [7:0] CCI_MPF_CSR_DFH      = 8'h00;
  localparam logic [7:0] CCI_MPF_CSR_UUID_L   = 8'h08;
  localparam logic [7:0] CCI_MPF_CSR_UUID_H   = 8'h10;
  localparam logic [7:0] CCI_MPF_CSR_MODE     = 8'h18;
  localparam logic [7:0] CCI_MPF_CSR_PT_PADDR = 8'h20;
  localparam logic [7:0] CCI_MPF_CSR_HITS     = 8'h28;
  localparam logic [7:0] CCI_MPF_CSR_MISSES   = 8'h30;

  localparam logic [7:0] CCI_MPF_CSR_WINDOW_BYTES = 8'h38;

endpackage

// File: rtl/cci_mpf_csr_rsp_fifo.sv
// Synchronous FIFO of MMIO read responses.
// Accepts an enqueue while full only if a dequeue happens the same cycle.
module cci_mpf_csr_rsp_fifo
  import cci_mpf_csrs_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enq_en,
  input  t_cci_mpf_csr_rd_rsp enq_data,
  output logic                notFull,
  input  logic                deq_en,
  output t_cci_mpf_csr_rd_rsp first,
  output logic                notEmpty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          deq_ok;

  t_cci_mpf_csr_rd_rsp mem_q [DEPTH];

  assign notEmpty = (cnt_q != '0);
  assign notFull  = (cnt_q != (AW+1)'(DEPTH));
  assign deq_ok   = deq_en && notEmpty;
  assign first    = notEmpty ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (enq_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (deq_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    cnt_d = cnt_q + (AW+1)'(enq_en) - (AW+1)'(deq_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; the count gates visibility.
  always_ff @(posedge clk) begin
    if (enq_en) mem_q[wr_ptr_q] <= enq_data;
  end

endmodule

// File: rtl/cci_mpf_csr_mmio_responder.sv
// Host MMIO responder for the MPF CSR window: decodes VTP control
// writes and queues read responses for the MMIO response arbiter.
module cci_mpf_csr_mmio_responder
  import cci_mpf_csrs_pkg::*;
#(
  parameter logic [15:0]  MPF_MMIO_BASE  = 16'h1000,
  parameter int           RD_QUEUE_DEPTH = 8,
  parameter logic [63:0]  DFH_VALUE      = 64'h0,
  parameter logic [127:0] FEATURE_UUID   = 128'h0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  mmio_req_valid,
  input  logic                  mmio_req_is_write,
  input  logic [15:0]           mmio_req_addr,
  input  logic                  mmio_req_len64,
  input  logic [8:0]            mmio_req_tid,
  input  logic [63:0]           mmio_req_data,
  output logic                  rsp_valid,
  output logic [8:0]            rsp_tid,
  output logic [63:0]           rsp_data,
  input  logic                  rsp_ready,
  input  logic [63:0]           stat_vtp_hits,
  input  logic [63:0]           stat_vtp_misses,
  output t_cci_mpf_vtp_csr_mode vtp_mode,
  output logic [63:0]           vtp_page_table_paddr,
  output logic                  vtp_page_table_set,
  output logic                  rd_overflow
);

  localparam logic [15:0] WIN_DW =
    16'(CCI_MPF_CSR_WINDOW_BYTES) >> 2;

  logic [15:0] off_dw;
  logic [7:0]  reg_off;
  logic        in_range, odd_dw;
  logic        wr_ok, rd_req;
  logic        mode_wr, pt_wr;
  logic [63:0] reg_val, rd_val;

  logic        mode_en_q, mode_en_d;
  logic        inval_q, inval_d;
  logic [63:0] pt_q, pt_d;
  logic        pt_set_q, pt_set_d;
  logic        ovf_q, ovf_d;

  logic                fifo_enq, fifo_notFull;
  logic                fifo_notEmpty, fifo_deq;
  t_cci_mpf_csr_rd_rsp fifo_in, fifo_first;

  // Addresses below the base wrap to large values and fall out of range.
  assign off_dw   = mmio_req_addr - MPF_MMIO_BASE;
  assign in_range = (off_dw < WIN_DW);
  assign odd_dw   = off_dw[0];
  assign reg_off  = {2'b00, off_dw[3:1], 3'b000};

  assign wr_ok   = mmio_req_valid && mmio_req_is_write && in_range
                   && mmio_req_len64 && !odd_dw;
  assign mode_wr = wr_ok && (reg_off == CCI_MPF_CSR_MODE);
  assign pt_wr   = wr_ok && (reg_off == CCI_MPF_CSR_PT_PADDR);
  assign rd_req  = mmio_req_valid && !mmio_req_is_write && in_range;

  always_comb begin
    reg_val = '0;
    unique case (reg_off)
      CCI_MPF_CSR_DFH:      reg_val = DFH_VALUE;
      CCI_MPF_CSR_UUID_L:   reg_val = FEATURE_UUID[63:0];
      CCI_MPF_CSR_UUID_H:   reg_val = FEATURE_UUID[127:64];
      CCI_MPF_CSR_MODE:     reg_val = {63'b0, mode_en_q};
      CCI_MPF_CSR_PT_PADDR: reg_val = pt_q;
      CCI_MPF_CSR_HITS:     reg_val = stat_vtp_hits;
      CCI_MPF_CSR_MISSES:   reg_val = stat_vtp_misses;
      default:              reg_val = '0;
    endcase
  end

  always_comb begin
    if (mmio_req_len64)
      rd_val = reg_val;
    else if (odd_dw)
      rd_val = {32'b0, reg_val[63:32]};
    else
      rd_val = {32'b0, reg_val[31:0]};
  end

  always_comb begin
    mode_en_d = mode_en_q;
    inval_d   = 1'b0;
    pt_d      = pt_q;
    pt_set_d  = pt_wr;
    ovf_d     = ovf_q;
    if (mode_wr) begin
      mode_en_d = mmio_req_data[0];
      inval_d   = mmio_req_data[1];
    end
    if (pt_wr) pt_d = mmio_req_data;
    if (rd_req && !fifo_notFull && !fifo_deq) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_en_q <= 1'b0;
      inval_q   <= 1'b0;
      pt_q      <= '0;
      pt_set_q  <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      mode_en_q <= mode_en_d;
      inval_q   <= inval_d;
      pt_q      <= pt_d;
      pt_set_q  <= pt_set_d;
      ovf_q     <= ovf_d;
    end
  end

  assign fifo_deq     = rsp_valid && rsp_ready;
  assign fifo_enq     = rd_req && (fifo_notFull || fifo_deq);
  assign fifo_in.tid  = mmio_req_tid;
  assign fifo_in.data = rd_val;

  cci_mpf_csr_rsp_fifo #(
    .DEPTH (RD_QUEUE_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq_en   (fifo_enq),
    .enq_data (fifo_in),
    .notFull  (fifo_notFull),
    .deq_en   (fifo_deq),
    .first    (fifo_first),
    .notEmpty (fifo_notEmpty)
  );

  assign rsp_valid = fifo_notEmpty;
  assign rsp_tid   = fifo_first.tid;
  assign rsp_data  = fifo_first.data;

  assign vtp_mode.enabled                 = mode_en_q;
  assign vtp_mode.inval_translation_cache = inval_q;
  assign vtp_page_table_paddr             = pt_q;
  assign vtp_page_table_set               = pt_set_q;
  assign rd_overflow                      = ovf_q;

endmodule

// File: doc/cci_mpf_csr_mmio_responder.md
Name: cci_mpf_csr_mmio_responder

Overview:
Host-facing responder for MPF's MMIO CSR window. It decodes host MMIO writes into MPF control state (the VTP mode and the page table base). It answers host MMIO reads that fall in the MPF window with feature-header, control and statistics values, queuing responses until the downstream MMIO response arbiter grants them. It sits between the CCI-P MMIO request path and the VTP shim, opposite the AFU's own MMIO responder.

Parameters:
MPF_MMIO_BASE, 16'h1000, window base in 4-byte MMIO address units; must be 8-byte aligned (bit 0 = 0).
RD_QUEUE_DEPTH, 8, read-response queue entries; power of 2, at least 2.
DFH_VALUE, 64'h0, constant returned at offset 0x00.
FEATURE_UUID, 128'h0, returned at 0x08 (low) and 0x10 (high).

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
mmio_req_valid  in  1  MMIO request this cycle; no backpressure
mmio_req_is_write  in  1  1 = write, 0 = read
mmio_req_addr  in  16  address in 4-byte units
mmio_req_len64  in  1  1 = 64-bit access, 0 = 32-bit
mmio_req_tid  in  9  read transaction ID
mmio_req_data  in  64  write data
rsp_valid  out  1  read response available
rsp_tid  out  9  response transaction ID
rsp_data  out  64  response data
rsp_ready  in  1  arbiter accepts the response this cycle
stat_vtp_hits  in  64  live counter, read-only at 0x28
stat_vtp_misses  in  64  live counter, read-only at 0x30
vtp_mode  out  2  t_cci_mpf_vtp_csr_mode {inval_translation_cache, enabled}
vtp_page_table_paddr  out  64  page table base
vtp_page_table_set  out  1  1-cycle pulse after a page-table base write
rd_overflow  out  1  sticky: an in-range read was dropped

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-low.
- Window: offset = (mmio_req_addr - MPF_MMIO_BASE) * 4 bytes. The request is in range when 0 <= offset < 0x38. Out-of-range requests are ignored: no response and no state change.
- Register map (byte offsets): 0x00 DFH RO; 0x08 UUID_L RO; 0x10 UUID_H RO; 0x18 MODE RW; 0x20 PT_PADDR RW; 0x28 HITS RO; 0x30 MISSES RO.
- Writes: only 64-bit writes at 8-byte-aligned offsets take effect. 32-bit writes and writes to RO offsets are dropped silently.
  - MODE write at cycle N: vtp_mode.enabled = data[0] from N+1. vtp_mode.inval_translation_cache = data[1] for exactly cycle N+1, then auto-clears.
  - PT_PADDR write at N: register updates at N+1; vtp_page_table_set pulses at N+1.
- Reads: data is sampled in the request cycle N and pushed to the queue as {tid, data}.
  - 64-bit reads return the full register. The read value of MODE bit 1 is always 0.
  - 32-bit read at an even dword returns the low half; at an odd dword it returns the high half in [31:0]. Bits [63:32] are 0.
  - A read at N of a register written at N-1 returns the new value.
- Latency: rsp_valid asserts no earlier than N+1 and holds until rsp_ready. rsp_tid and rsp_data are stable while rsp_valid && !rsp_ready. Queue order is FIFO.
- Full and empty:
  - Pop occurs on rsp_valid && rsp_ready.
  - Push while full with a simultaneous pop is accepted.
  - Push while full without a pop is dropped, and rd_overflow sets and holds until reset.
  - rsp_valid = 0 when the queue is empty.
- Pointers wrap modulo RD_QUEUE_DEPTH. The occupancy counter is log2(DEPTH)+1 bits wide.
- Reset values: rsp_valid 0, rsp_tid 0, rsp_data 0, vtp_mode 0, vtp_page_table_paddr 0, vtp_page_table_set 0, rd_overflow 0.
- Reset asserted mid-operation: queued responses are discarded and no response is emitted after reset.
- Only one request arrives per cycle, so reads and writes cannot collide.

Decomposition:
- Add to package cci_mpf_csrs_pkg:
  - byte-offset localparams for the register map;
  - the window size constant;
  - struct t_cci_mpf_csr_rd_rsp {tid[8:0], data[63:0]}.
- Reuse the existing t_cci_mpf_vtp_csr_mode.
- Sub-module cci_mpf_csr_rsp_fifo: a parameterised synchronous FIFO of t_cci_mpf_csr_rd_rsp with notFull/notEmpty.

Test Plan:
1. 64-bit write 64'h3 to MODE, then 64-bit read tid 5 -> vtp_mode = 2'b11 for one cycle then 2'b01; response tid 5, data 64'h1.
2. 64-bit write 64'hDEAD_B000 to PT_PADDR -> vtp_page_table_set pulses once; 32-bit reads at dword offsets 8 and 9 return 32'hDEAD_B000 and 0.
3. stat_vtp_hits = 64'h1_0000_0005; 32-bit read at odd dword of 0x28 -> rsp_data = 64'h1.
4. Read at base+0x40, and a write to 0x00 -> no response; DFH still reads DFH_VALUE.
5. rsp_ready = 0; issue 9 reads, tids 0..8 -> tids 0..7 queued, tid 8 dropped, rd_overflow = 1; release rsp_ready -> responses tids 0..7 in order.
6. Queue 3 reads, assert reset_n = 0 for 1 cycle -> rsp_valid = 0 and all outputs at reset values; no stale responses afterward.
